// File: rtl/arb_pkg.sv
// Shared arbiter definitions: FSM state encoding and legal parameter ranges.
package arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE    = 2'd0;
  localparam state_t GRANT   = 2'd1;
  localparam state_t RELEASE = 2'd2;

  localparam int N_MIN      = 2;
  localparam int N_MAX      = 8;
  localparam int HOLD_MIN   = 1;
  localparam int HOLD_LIMIT = 255;

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner select: first set req bit scanning upward from ptr, wrapping modulo N.
module rr_pick
  import arb_pkg::*;
#(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] winner,
  output logic           any_req
);

  logic [IDW:0] sum_s;
  logic [IDW:0] idx_s;
  logic         found_s;

  // Scan all N positions starting at ptr; the first hit wins.
  always_comb begin
    winner  = {IDW{1'b0}};
    sum_s   = {(IDW+1){1'b0}};
    idx_s   = {(IDW+1){1'b0}};
    found_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      sum_s = {1'b0, ptr} + (IDW+1)'(i);
      idx_s = (sum_s >= (IDW+1)'(N)) ? (sum_s - (IDW+1)'(N)) : sum_s;
      if (!found_s && req[idx_s[IDW-1:0]]) begin
        found_s = 1'b1;
        winner  = idx_s[IDW-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/rr_moore_arbiter.sv
// Moore round-robin arbiter with a per-grant hold limit and a one-cycle dead cycle
// between owners. Outputs are registered and decoded from next state, never from req.
module rr_moore_arbiter
  import arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int HOLD_MAX = 8,
  localparam int IDW      = $clog2(N),
  localparam int CW       = $clog2(HOLD_MAX + 1)
) (
  input  logic           clk,
  input  logic           areset,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           busy,
  output logic           timeout
);

  if (N < N_MIN || N > N_MAX) begin : g_bad_n
    $error("rr_moore_arbiter: N outside legal range");
  end
  if (HOLD_MAX < HOLD_MIN || HOLD_MAX > HOLD_LIMIT) begin : g_bad_hold
    $error("rr_moore_arbiter: HOLD_MAX outside legal range");
  end

  state_t         state_r, state_s;
  logic [IDW-1:0] owner_r, owner_s;
  logic [IDW-1:0] ptr_r, ptr_s;
  logic [CW-1:0]  hold_cnt_r, hold_cnt_s;
  logic           revoke_s;
  logic [IDW-1:0] winner_s;
  logic           any_req_s;
  logic [N-1:0]   grant_s;
  logic [IDW-1:0] grant_id_s;
  logic           busy_s;
  logic           timeout_s;

  // ptr_r already holds the advanced pointer while in RELEASE, so one picker serves both states.
  rr_pick #(.N(N)) u_pick (
    .req     (req),
    .ptr     (ptr_r),
    .winner  (winner_s),
    .any_req (any_req_s)
  );

  // State, pointer, hold counter and output registers; reset clears everything at once.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_r    <= IDLE;
      owner_r    <= {IDW{1'b0}};
      ptr_r      <= {IDW{1'b0}};
      hold_cnt_r <= {CW{1'b0}};
      grant      <= {N{1'b0}};
      grant_id   <= {IDW{1'b0}};
      busy       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state_r    <= state_s;
      owner_r    <= owner_s;
      ptr_r      <= ptr_s;
      hold_cnt_r <= hold_cnt_s;
      grant      <= grant_s;
      grant_id   <= grant_id_s;
      busy       <= busy_s;
      timeout    <= timeout_s;
    end
  end

  // Next-state logic; a dropped request beats hold expiry, so revoke only fires while still requested.
  always_comb begin
    state_s    = state_r;
    owner_s    = owner_r;
    ptr_s      = ptr_r;
    hold_cnt_s = hold_cnt_r;
    revoke_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          state_s    = GRANT;
          owner_s    = winner_s;
          hold_cnt_s = {CW{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        hold_cnt_s = hold_cnt_r + CW'(1);
        if (!req[owner_r]) begin
          state_s = RELEASE;
          ptr_s   = (owner_r == IDW'(N - 1)) ? {IDW{1'b0}} : owner_r + IDW'(1);
        end else if (hold_cnt_r == CW'(HOLD_MAX - 1)) begin
          state_s  = RELEASE;
          revoke_s = 1'b1;
          ptr_s    = (owner_r == IDW'(N - 1)) ? {IDW{1'b0}} : owner_r + IDW'(1);
        end else begin
          state_s = GRANT;
        end
      end
      RELEASE: begin
        if (any_req_s) begin
          state_s    = GRANT;
          owner_s    = winner_s;
          hold_cnt_s = {CW{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s    = IDLE;
        owner_s    = {IDW{1'b0}};
        hold_cnt_s = {CW{1'b0}};
      end
    endcase
  end

  // Output decode from the state being entered, so registered outputs line up with state_r.
  always_comb begin
    grant_s    = {N{1'b0}};
    grant_id_s = {IDW{1'b0}};
    busy_s     = 1'b0;
    timeout_s  = 1'b0;
    case (state_s)
      GRANT: begin
        grant_s[owner_s] = 1'b1;
        grant_id_s       = owner_s;
        busy_s           = 1'b1;
      end
      RELEASE: begin
        timeout_s = revoke_s;
      end
      IDLE: begin
        busy_s = 1'b0;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rr_moore_arbiter.sv
// Directed bench for rr_moore_arbiter (N=4, HOLD_MAX=8) with a per-cycle expectation queue.
module tb_rr_moore_arbiter;

  logic       clk;
  logic       areset;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int errors = 0;
  int step   = 0;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] id;
    logic       b;
    logic       t;
  } exp_t;

  exp_t sb_q[$];

  rr_moore_arbiter #(.N(4), .HOLD_MAX(8)) dut (
    .clk      (clk),
    .areset   (areset),
    .req      (req),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step %0d: observed %0h expected %0h", tag, step, obs, exp);
    end
  endtask

  function automatic logic [1:0] id_of(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (g[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Drive req for the next edge, queue the outputs expected after it, then compare.
  task automatic cyc(input logic [3:0] r, input logic [3:0] g, input logic t);
    exp_t e;
    exp_t o;
    req  = r;
    e.g  = g;
    e.id = id_of(g);
    e.b  = |g;
    e.t  = t;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    step++;
    o = sb_q.pop_front();
    chk("grant",    {4'b0000, grant},    {4'b0000, o.g});
    chk("grant_id", {6'b000000, grant_id}, {6'b000000, o.id});
    chk("busy",     {7'b0000000, busy},    {7'b0000000, o.b});
    chk("timeout",  {7'b0000000, timeout}, {7'b0000000, o.t});
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_grant"},   {4'b0000, grant},      8'h00);
    chk({tag, "_id"},      {6'b000000, grant_id}, 8'h00);
    chk({tag, "_busy"},    {7'b0000000, busy},    8'h00);
    chk({tag, "_timeout"}, {7'b0000000, timeout}, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] gk;
    areset = 1'b1;
    req    = 4'b1111;
    #12;
    chk_idle_outputs("reset");
    @(posedge clk);
    #1;
    chk_idle_outputs("reset_held");
    areset = 1'b0;

    // Full rotation with every grant revoked by the hold limit
    for (int k = 0; k < 5; k++) begin
      gk = 4'b0001 << (k % 4);
      repeat (8) cyc(4'b1111, gk, 1'b0);
      cyc(4'b1111, 4'b0000, 1'b1);
    end
    cyc(4'b0000, 4'b0000, 1'b0);

    // Voluntary release after 4 cycles; pointer moves to 3
    repeat (4) cyc(4'b0100, 4'b0100, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b0);

    // Pointer at 3 picks requester 3 first, then wraps to 0 after it drops
    repeat (3) cyc(4'b1001, 4'b1000, 1'b0);
    cyc(4'b0001, 4'b0000, 1'b0);
    cyc(4'b1001, 4'b0001, 1'b0);

    // Drop on the 8th grant cycle beats expiry: no timeout
    repeat (7) cyc(4'b1001, 4'b0001, 1'b0);
    cyc(4'b1000, 4'b0000, 1'b0);
    cyc(4'b1000, 4'b1000, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b0);

    // Pulse shorter than a cycle, not present at any edge
    req = 4'b0100;
    #2;
    req = 4'b0000;
    @(posedge clk);
    #1;
    chk_idle_outputs("glitch");

    // Sole requester may win back-to-back, still with a dead cycle
    repeat (8) cyc(4'b0010, 4'b0010, 1'b0);
    cyc(4'b0010, 4'b0000, 1'b1);
    repeat (3) cyc(4'b0010, 4'b0010, 1'b0);

    // Asynchronous reset in the 3rd grant cycle clears outputs before any edge
    #3;
    areset = 1'b1;
    #1;
    chk_idle_outputs("async_rst");
    @(posedge clk);
    #1;
    chk_idle_outputs("async_rst_held");
    areset = 1'b0;
    // Pointer restarted at 0 so requester 1 beats requester 3
    cyc(4'b1010, 4'b0010, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
